// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, controller states and
// the classifier that separates iterative ops from single-cycle ops.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLT  = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_DIVU = 4'b1011,
        OP_REMU = 4'b1100
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iter(op_t op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine: shift-add multiply (low half) and restoring divide,
// one iteration per step. Sequencing and the iteration count live in the parent.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    input  logic             last_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // acc: product accumulator (MUL) or partial remainder (DIV).
    // sh_a: multiplier (MUL) or dividend shifting out / quotient shifting in (DIV).
    // sh_b: multiplicand (MUL) or divisor (DIV).
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    op_t              mode_q, mode_d;
    logic [WIDTH:0]   trial, diff;

    assign trial = {acc_q[WIDTH-1:0], sh_a_q[WIDTH-1]};
    assign diff  = trial - {1'b0, sh_b_q};

    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves it unassigned and no latch is inferred.
        acc_d  = acc_q;
        sh_a_d = sh_a_q;
        sh_b_d = sh_b_q;
        mode_d = mode_q;
        if (start_i) begin
            acc_d  = '0;
            sh_a_d = a_i;
            sh_b_d = b_i;
            mode_d = op_t'(mode_i);
        end else if (step_i) begin
            if (mode_q == OP_MUL) begin
                if (sh_a_q[0]) acc_d = acc_q + {1'b0, sh_b_q};
                sh_b_d = sh_b_q << 1;
                sh_a_d = sh_a_q >> 1;
            end else if (!diff[WIDTH]) begin
                acc_d  = diff;
                sh_a_d = {sh_a_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d  = trial;
                sh_a_d = {sh_a_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Result reflects the state after the current step, so the parent can latch it on done.
    assign result_o = (mode_q == OP_DIVU) ? sh_a_d : acc_d[WIDTH-1:0];
    assign done_o   = step_i & last_i;

    // NOTE: sequential state uses non-blocking assignments; all engine registers clear on reset so an aborted op leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            sh_a_q <= '0;
            sh_b_q <= '0;
            mode_q <= OP_AND;
        end else begin
            acc_q  <= acc_d;
            sh_a_q <= sh_a_d;
            sh_b_q <= sh_b_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops answer one cycle after accept, MUL/DIVU/REMU
// run the iterative engine for WIDTH cycles. Result held until out_ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             accept, start, step;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    op_t              op_in;

    assign op_in = op_t'(op);
    assign shamt = src_b[SHW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = is_iter(op_in) ? BUSY : DONE;
            BUSY:    if (eng_done)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        busy      = (state_q == BUSY);
        out_valid = (state_q == DONE);
        accept    = in_valid && in_ready;
        start     = accept && is_iter(op_in);
        step      = busy;
    end

    always_comb begin
        alu_res = '0;
        case (op_in)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLTU: alu_res = WIDTH'(src_a < src_b);
            OP_SRA:  alu_res = $signed(src_a) >>> shamt;
            OP_SLT:  alu_res = WIDTH'($signed(src_a) < $signed(src_b));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (start)     cnt_d = '0;
        else if (step) cnt_d = cnt_q + 1'b1;
        if (accept && !is_iter(op_in)) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
        end else if (eng_done) begin
            result_d = eng_result;
            zero_d   = (eng_result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .mode_i   (op),
        .a_i      (src_a),
        .b_i      (src_b),
        .step_i   (step),
        .last_i   (cnt_q == CNT_LAST),
        .done_o   (eng_done),
        .result_o (eng_result)
    );

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_alu;

    logic        clk, rst_n, in_valid, out_ready, use8;
    logic [3:0]  op;
    logic [31:0] src_a, src_b;

    logic        in_ready32, out_valid32, zero32, busy32;
    logic [31:0] result32;
    logic        in_ready8, out_valid8, zero8, busy8;
    logic [7:0]  result8;

    logic        v_in_ready, v_out_valid, v_zero, v_busy;
    logic [31:0] v_result;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !use8), .in_ready(in_ready32),
        .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid32),
        .out_ready(out_ready), .result(result32), .zero(zero32), .busy(busy32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && use8), .in_ready(in_ready8),
        .op(op), .src_a(src_a[7:0]), .src_b(src_b[7:0]), .out_valid(out_valid8),
        .out_ready(out_ready), .result(result8), .zero(zero8), .busy(busy8)
    );

    assign v_in_ready  = use8 ? in_ready8  : in_ready32;
    assign v_out_valid = use8 ? out_valid8 : out_valid32;
    assign v_zero      = use8 ? zero8      : zero32;
    assign v_busy      = use8 ? busy8      : busy32;
    assign v_result    = use8 ? {24'h0, result8} : result32;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int w, input logic [3:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        mask, ua, ub, r;
        logic signed [63:0] sa, sb;
        int                 sh;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'h0, a} & mask;
        ub   = {32'h0, b} & mask;
        sa   = $signed(ua << (64 - w)) >>> (64 - w);
        sb   = $signed(ub << (64 - w)) >>> (64 - w);
        sh   = int'(ub) & (w - 1);
        case (o)
            4'h0:    r = ua & ub;
            4'h1:    r = ua | ub;
            4'h2:    r = ua + ub;
            4'h3:    r = ua ^ ub;
            4'h4:    r = ua << sh;
            4'h5:    r = ua >> sh;
            4'h6:    r = ua - ub;
            4'h7:    r = {63'h0, ua < ub};
            4'h8:    r = sa >>> sh;
            4'h9:    r = {63'h0, sa < sb};
            4'hA:    r = ua * ub;
            4'hB:    r = (ub == 0) ? mask : ua / ub;
            4'hC:    r = (ub == 0) ? ua : ua % ub;
            default: r = 64'h0;
        endcase
        return 32'(r & mask);
    endfunction

    // Issue one op, measure accept-to-out_valid latency and busy cycles, check, then drain.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          w, k, busy_cnt, wait_cnt;
        logic [31:0] exp_v;
        bit          iter;
        w     = use8 ? 8 : 32;
        exp_v = ref_alu(w, o, a, b);
        iter  = (o == 4'hA) || (o == 4'hB) || (o == 4'hC);
        @(negedge clk);
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        wait_cnt = 0;
        while (!v_in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check({tag, " in_ready"}, 32'(v_in_ready), 32'd1);
        @(posedge clk);
        k = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                in_valid = 1'b0; op = 4'($urandom); src_a = $urandom; src_b = $urandom;
            end
            if (v_busy) busy_cnt++;
        end while (!v_out_valid && k < 200);
        check({tag, " latency"}, 32'(k), iter ? 32'(w + 1) : 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), iter ? 32'(w) : 32'd0);
        check({tag, " result"}, v_result, exp_v);
        check({tag, " zero"}, 32'(v_zero), 32'(exp_v == 32'h0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(v_out_valid), 32'd0);
        check({tag, " in_ready_back"}, 32'(v_in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use8 = 1'b0;
        op = 4'h0; src_a = '0; src_b = '0;

        #12;
        check("rst result32", result32, 32'h0);
        check("rst zero32", 32'(zero32), 32'd0);
        check("rst out_valid32", 32'(out_valid32), 32'd0);
        check("rst busy32", 32'(busy32), 32'd0);
        check("rst in_ready32", 32'(in_ready32), 32'd0);
        check("rst result8", 32'(result8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel in_ready32", 32'(in_ready32), 32'd1);
        check("rel in_ready8", 32'(in_ready8), 32'd1);

        // Legacy and new single-cycle ops
        do_op(4'h2, 32'hFFFF_FFFF, 32'h1, "ADD wrap");
        do_op(4'h6, 32'd5, 32'd7, "SUB");
        do_op(4'h7, 32'hFFFF_FFFF, 32'h1, "SLTU");
        do_op(4'h9, 32'hFFFF_FFFF, 32'h1, "SLT");
        do_op(4'h8, 32'h8000_0000, 32'h21, "SRA");
        do_op(4'h4, 32'h1, 32'd31, "SLL");
        do_op(4'h5, 32'h8000_0000, 32'd4, "SRL");
        do_op(4'hE, 32'h1234_5678, 32'h9, "reserved");

        // Iterative ops
        do_op(4'hA, 32'h0001_0001, 32'h0001_0001, "MUL");
        do_op(4'hB, 32'd100, 32'd7, "DIVU");
        do_op(4'hC, 32'd100, 32'd7, "REMU");
        do_op(4'hB, 32'd9, 32'd0, "DIVU by0");
        do_op(4'hC, 32'd9, 32'd0, "REMU by0");

        // Backpressure: result held, new request waits until after the handshake
        @(negedge clk);
        in_valid = 1'b1; op = 4'h3; src_a = 32'hF0F0_1234; src_b = 32'h0F0F_1234;
        check("bp in_ready", 32'(in_ready32), 32'd1);
        @(posedge clk);
        @(negedge clk);
        op = 4'h6; src_a = 32'd10; src_b = 32'd3;
        check("bp out_valid", 32'(out_valid32), 32'd1);
        check("bp result", result32, 32'hFFFF_0000);
        held = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp hold result", result32, held);
            check("bp hold out_valid", 32'(out_valid32), 32'd1);
            check("bp hold in_ready", 32'(in_ready32), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp drop out_valid", 32'(out_valid32), 32'd0);
        check("bp drop in_ready", 32'(in_ready32), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp pending out_valid", 32'(out_valid32), 32'd1);
        check("bp pending result", result32, 32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a divide
        @(negedge clk);
        in_valid = 1'b1; op = 4'hB; src_a = 32'd1000; src_b = 32'd3;
        check("mid rst in_ready", 32'(in_ready32), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid rst busy before", 32'(busy32), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid rst result", result32, 32'h0);
        check("mid rst zero", 32'(zero32), 32'd0);
        check("mid rst busy", 32'(busy32), 32'd0);
        check("mid rst out_valid", 32'(out_valid32), 32'd0);
        check("mid rst in_ready", 32'(in_ready32), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid rst release in_ready", 32'(in_ready32), 32'd1);
        do_op(4'h2, 32'd2, 32'd3, "post-rst ADD");
        do_op(4'hB, 32'd1000, 32'd3, "post-rst DIVU");

        // WIDTH=8 instance
        use8 = 1'b1;
        do_op(4'hA, 32'h10, 32'h10, "w8 MUL");
        do_op(4'hB, 32'hFF, 32'h10, "w8 DIVU");
        do_op(4'h8, 32'h80, 32'h9, "w8 SRA");

        // Random mix across both widths
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            use8 = (i % 4 == 3);
            ro   = 4'($urandom_range(0, 15));
            ra   = $urandom;
            rb   = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            do_op(ro, ra, rb, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
